// File: rtl/muldiv_sequencer_if.sv
// Handshake and data bundle between the EX stage (master) and the
// RV32M multiply/divide sequencer (slave).
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      func3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result;

    // EX side: issues the M-op and consumes stall/result.
    modport master (
        output start, func3, op_a, op_b, flush,
        input  stall, busy, result_valid, result
    );

    // Sequencer side.
    modport slave (
        input  start, func3, op_a, op_b, flush,
        output stall, busy, result_valid, result
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M sequencer beside the EX-stage ALU: a two-cycle
// registered multiply and a 32-iteration restoring divide, holding the
// pipeline with a combinational stall until the one-cycle result pulse.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input logic               clk,
    input logic               rst,
    muldiv_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } state_t;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state;
    logic [2:0]      op_q;      // captured func3
    logic [XLEN-1:0] a_q;       // multiplicand, or dividend/quotient shift register
    logic [XLEN-1:0] b_q;       // multiplier, or divisor magnitude
    logic [XLEN-1:0] rem_q;     // partial remainder
    logic [5:0]      cnt;       // divide iterations left
    logic            neg_q;     // negate the divide result in FIX
    logic [XLEN-1:0] result_q;
    logic            valid_q;
    logic            busy_q;

    // Operand decode at acceptance time (func3[0] = 0 means a signed divide).
    logic            div_signed;
    logic            a_neg;
    logic            b_neg;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;

    assign div_signed = ~bus.func3[0];
    assign a_neg      = bus.op_a[XLEN-1];
    assign b_neg      = bus.op_b[XLEN-1];
    assign div_zero   = (bus.op_b == '0);
    assign div_ovf    = div_signed && (bus.op_a == INT_MIN) && (bus.op_b == '1);
    assign a_mag      = (div_signed && a_neg) ? -bus.op_a : bus.op_a;
    assign b_mag      = (div_signed && b_neg) ? -bus.op_b : bus.op_b;

    // Multiply: sign-extend each operand to 2*XLEN as the op requires; the
    // low 2*XLEN bits of an unsigned product of those are the exact result.
    logic              mul_a_sign;
    logic              mul_b_sign;
    logic [2*XLEN-1:0] mul_a_ext;
    logic [2*XLEN-1:0] mul_b_ext;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res;

    assign mul_a_sign = ((op_q == 3'b001) || (op_q == 3'b010)) && a_q[XLEN-1];
    assign mul_b_sign = (op_q == 3'b001) && b_q[XLEN-1];
    assign mul_a_ext  = {{XLEN{mul_a_sign}}, a_q};
    assign mul_b_ext  = {{XLEN{mul_b_sign}}, b_q};
    assign prod       = mul_a_ext * mul_b_ext;
    assign mul_res    = (op_q == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    // Restoring divide step: the shifted remainder is one bit wider than the
    // divisor, and the borrow out of the XLEN+1 bit subtract is the compare.
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   diff;
    logic            q_bit;
    logic [XLEN-1:0] fix_src;
    logic [XLEN-1:0] fix_res;

    assign rem_shift = {rem_q, a_q[XLEN-1]};
    assign diff      = rem_shift - {1'b0, b_q};
    assign q_bit     = ~diff[XLEN];
    assign fix_src   = op_q[1] ? rem_q : a_q;
    assign fix_res   = neg_q ? -fix_src : fix_src;

    // Sequencer FSM with registered result, result_valid and busy.
    // NOTE: every register here is written with <= so all of them update
    // together from the values present before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else if (bus.flush) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (bus.start) begin
                        op_q   <= bus.func3;
                        rem_q  <= '0;
                        cnt    <= 6'(XLEN - 1);
                        neg_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (!bus.func3[2]) begin
                            a_q   <= bus.op_a;
                            b_q   <= bus.op_b;
                            state <= MUL;
                        end else if (div_zero) begin
                            result_q <= bus.func3[1] ? bus.op_a : '1;
                            valid_q  <= 1'b1;
                            state    <= DONE;
                        end else if (div_ovf) begin
                            result_q <= bus.func3[1] ? '0 : INT_MIN;
                            valid_q  <= 1'b1;
                            state    <= DONE;
                        end else begin
                            a_q   <= a_mag;
                            b_q   <= b_mag;
                            neg_q <= div_signed && (bus.func3[1] ? a_neg : (a_neg ^ b_neg));
                            state <= DIV;
                        end
                    end
                end
                MUL: begin
                    result_q <= mul_res;
                    valid_q  <= 1'b1;
                    state    <= DONE;
                end
                DIV: begin
                    a_q   <= {a_q[XLEN-2:0], q_bit};
                    rem_q <= q_bit ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
                    cnt   <= cnt - 6'd1;
                    if (cnt == 6'd0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result_q <= fix_res;
                    valid_q  <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    // A start still high here belongs to the retiring op.
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Stall is combinational so EX freezes in the very cycle it presents the op;
    // reset and flush both force it low.
    assign bus.stall        = bus.start && !valid_q && !bus.flush && !rst;
    assign bus.busy         = busy_q;
    assign bus.result_valid = valid_q;
    assign bus.result       = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: expected results are
// queued as each op is issued and popped when result_valid appears.
module tb_muldiv_sequencer;

    logic clk;
    logic rst;

    muldiv_sequencer_if #(.XLEN(32)) bus ();

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Issue one op at posedge+1 of cycle N, scramble the operands a cycle
    // later, and check hold behaviour, latency and the scoreboard result.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int lat);
        int          seen;
        logic        hold_ok;
        logic [31:0] got;
        logic [31:0] want;
        exp_q.push_back(exp_res);
        bus.start = 1'b1;
        bus.func3 = f3;
        bus.op_a  = a;
        bus.op_b  = b;
        seen      = -1;
        hold_ok   = 1'b1;
        got       = 'x;
        for (int c = 0; c <= lat + 3; c++) begin
            @(negedge clk);
            if (bus.result_valid === 1'b1) begin
                seen = c;
                got  = bus.result;
                check({tag, " stall at result"}, {31'b0, bus.stall}, 32'd0);
                break;
            end
            if (bus.stall !== 1'b1) hold_ok = 1'b0;
            if (c == 0 && bus.busy !== 1'b0) hold_ok = 1'b0;
            if (c > 0 && bus.busy !== 1'b1) hold_ok = 1'b0;
            @(posedge clk);
            #1;
            if (c == 0) begin
                bus.op_a = ~a;
                bus.op_b = b + 32'd3;
            end
        end
        check({tag, " stall/busy hold"}, {31'b0, hold_ok}, 32'd1);
        check({tag, " latency"}, 32'(seen), 32'(lat));
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({tag, " result"}, got, want);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    initial begin
        logic ok;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.func3 = 3'b000;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.flush = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset busy", {31'b0, bus.busy}, 32'd0);
        check("reset result_valid", {31'b0, bus.result_valid}, 32'd0);
        check("reset result", bus.result, 32'd0);
        check("reset stall", {31'b0, bus.stall}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Multiplies, back to back
        run_op("MUL 7*-3",        3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2);
        run_op("MULHU -1*-1",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);
        run_op("MULH -1*-1",      3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2);
        run_op("MULHSU -1*max",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);

        // Restoring divides
        run_op("DIV -7/2",        3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
        run_op("REM -7%2",        3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
        run_op("DIVU 100/7",      3'b101, 32'd100,      32'd7,        32'd14,       34);
        run_op("REMU 100%7",      3'b111, 32'd100,      32'd7,        32'd2,        34);
        run_op("DIV 20/-3",       3'b100, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 34);
        run_op("REM 20%-3",       3'b110, 32'd20,       32'hFFFFFFFD, 32'd2,        34);
        run_op("DIVU min/max",    3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        34);
        run_op("REMU min%max",    3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34);

        // Special cases
        run_op("DIVU 5/0",        3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("REM 5%0",         3'b110, 32'd5,        32'd0,        32'd5,        1);
        run_op("DIV ovf",         3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("REM ovf",         3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

        // Flush at N+10 of a DIV, then a MUL started at N+12
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.func3 = 3'b100;
        bus.op_a  = 32'd1000;
        bus.op_b  = 32'd7;
        ok        = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.result_valid !== 1'b0 || bus.stall !== 1'b1) ok = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush stall gated", {31'b0, bus.stall}, 32'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("flush pre-kill hold", {31'b0, ok}, 32'd1);
        check("flush busy", {31'b0, bus.busy}, 32'd0);
        check("flush result_valid", {31'b0, bus.result_valid}, 32'd0);
        @(posedge clk);
        #1;
        run_op("MUL after flush", 3'b000, 32'd6, 32'd7, 32'd42, 2);

        // Asynchronous reset at N+5 of a REM
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.func3 = 3'b110;
        bus.op_a  = 32'd12345;
        bus.op_b  = 32'd100;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
        end
        #3;
        rst = 1'b1;
        #1;
        check("async rst busy", {31'b0, bus.busy}, 32'd0);
        check("async rst result_valid", {31'b0, bus.result_valid}, 32'd0);
        check("async rst result", bus.result, 32'd0);
        check("async rst stall", {31'b0, bus.stall}, 32'd0);
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ok  = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) ok = 1'b0;
        end
        check("no pulse after rst", {31'b0, ok}, 32'd1);
        @(posedge clk);
        #1;
        run_op("DIVU max/1 post-rst", 3'b101, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 34);

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
